// File: rtl/vec_reg_file.sv
// Vector register file for the decode stage: NUM_REGS entries of DATA_W bits,
// two combinational read ports for the operand path and one synchronous
// write port driven by writeback. Every entry is an ordinary register (no
// hardwired zero). An asynchronous active-low reset clears the whole array.
// Reads are not bypassed: a read of the register being written shows the
// old contents until the rising edge that performs the write.
module vec_reg_file #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] InputData,
    output logic [DATA_W-1:0] Rout1,
    output logic [DATA_W-1:0] Rout2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear the whole array on reset (dominates any write); otherwise store
    // InputData into the addressed entry when WriteEn is high at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WriteEn) begin
            regs[rd] <= InputData;
        end
    end

    // Zero-latency read ports; they follow address changes within the cycle.
    assign Rout1 = regs[Rs1];
    assign Rout2 = regs[Rs2];

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed plus randomized bench for vec_reg_file. A plain array holds the
// expected register contents; every observed read is compared against it.
module tb_vec_reg_file;

    localparam int DATA_W   = 256;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              clk;
    logic              rst;
    logic              WriteEn;
    logic [ADDR_W-1:0] Rs1;
    logic [ADDR_W-1:0] Rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] InputData;
    logic [DATA_W-1:0] Rout1;
    logic [DATA_W-1:0] Rout2;

    // Expected register contents.
    logic [DATA_W-1:0] model [NUM_REGS];

    int n_checks = 0;
    int n_fail   = 0;

    vec_reg_file #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .WriteEn  (WriteEn),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .rd       (rd),
        .InputData(InputData),
        .Rout1    (Rout1),
        .Rout2    (Rout2)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both read ports against the model at the current addresses.
    task automatic check_ports(input string tag);
        check({tag, "_rout1"}, Rout1, model[Rs1]);
        check({tag, "_rout2"}, Rout2, model[Rs2]);
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DATA_W / 32; k++) begin
            v[k*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NUM_REGS; k++) begin
            model[k] = '0;
        end
    endfunction

    // One write through a rising edge; inputs change at the falling edge.
    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        WriteEn   = 1'b1;
        rd        = a;
        InputData = d;
        @(posedge clk);
        if (rst) model[a] = d;
        #1;
        WriteEn = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] msb_lsb;
        logic [ADDR_W-1:0] addr_a;
        logic [ADDR_W-1:0] addr_b;

        ones      = '1;
        msb_lsb   = '0;
        msb_lsb[DATA_W-1] = 1'b1;
        msb_lsb[0]        = 1'b1;

        rst       = 1'b0;
        WriteEn   = 1'b0;
        Rs1       = '0;
        Rs2       = '0;
        rd        = '0;
        InputData = '0;
        model_clear();

        // Reset held for two cycles, released away from the rising edge.
        repeat (2) @(posedge clk);
        #1;
        check("during_reset_rout1", Rout1, '0);
        @(negedge clk);
        rst = 1'b1;

        // Every address reads zero after reset.
        for (int i = 0; i < NUM_REGS; i++) begin
            Rs1 = ADDR_W'(i);
            Rs2 = ADDR_W'(NUM_REGS - 1 - i);
            #1;
            check("post_reset_zero_rout1", Rout1, '0);
            check("post_reset_zero_rout2", Rout2, '0);
        end

        // Basic write/read.
        Rs1 = 5'd16;
        Rs2 = 5'd18;
        write_reg(5'd16, DATA_W'(100));
        check("basic_w16_rout1", Rout1, DATA_W'(100));
        check("basic_w16_rout2", Rout2, '0);
        write_reg(5'd18, DATA_W'(100));
        check("basic_w18_rout2", Rout2, DATA_W'(100));
        check("basic_w18_rout1", Rout1, DATA_W'(100));

        // Enable gating: WriteEn low for three edges with changing data.
        Rs1 = 5'd5;
        @(negedge clk);
        WriteEn   = 1'b0;
        rd        = 5'd5;
        InputData = ones;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            InputData = rand_data();
        end
        #1;
        check("gate_reg5_stays_zero", Rout1, '0);

        // WriteEn pulsed high only between edges must not write.
        @(posedge clk);
        #2;
        WriteEn = 1'b1;
        #2;
        WriteEn = 1'b0;
        @(posedge clk);
        #1;
        check("gate_between_edges", Rout1, '0);

        // No bypass: old value before the edge, new value right after.
        Rs1 = 5'd7;
        @(negedge clk);
        WriteEn   = 1'b1;
        rd        = 5'd7;
        InputData = DATA_W'(16'hABCD);
        #1;
        check("nobypass_before_edge", Rout1, '0);
        @(posedge clk);
        model[7] = DATA_W'(16'hABCD);
        #1;
        check("nobypass_after_edge", Rout1, DATA_W'(16'hABCD));
        WriteEn = 1'b0;

        // Full width and isolation at both ends of the address range.
        write_reg(5'd31, msb_lsb);
        write_reg(5'd0, DATA_W'(1));
        Rs1 = 5'd31;
        Rs2 = 5'd0;
        #1;
        check("width_r31_rs1", Rout1, msb_lsb);
        check("width_r0_rs2", Rout2, DATA_W'(1));
        Rs1 = 5'd0;
        Rs2 = 5'd31;
        #1;
        check("width_r0_rs1", Rout1, DATA_W'(1));
        check("width_r31_rs2", Rout2, msb_lsb);
        Rs1 = 5'd30;
        Rs2 = 5'd1;
        #1;
        check("isolate_r30", Rout1, '0);
        check("isolate_r1", Rout2, '0);

        // Same address on both ports.
        Rs1 = 5'd31;
        Rs2 = 5'd31;
        #1;
        check("same_addr_rout1", Rout1, msb_lsb);
        check("same_addr_rout2", Rout2, msb_lsb);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            WriteEn   = ($urandom_range(0, 3) != 0);
            rd        = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            InputData = rand_data();
            Rs1       = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            Rs2       = ($urandom_range(0, 7) == 0) ? Rs1
                                                    : ADDR_W'($urandom_range(0, NUM_REGS - 1));
            if ($urandom_range(0, 3) == 0) Rs1 = rd;
            #1;
            check_ports("rand_pre_edge");
            @(posedge clk);
            if (WriteEn) model[rd] = InputData;
            #1;
            check_ports("rand_post_edge");
        end
        @(negedge clk);
        WriteEn = 1'b0;

        // Full sweep of stored state after random traffic.
        for (int i = 0; i < NUM_REGS; i++) begin
            Rs1 = ADDR_W'(i);
            Rs2 = ADDR_W'(i);
            #1;
            check_ports("sweep");
        end

        // Asynchronous reset between edges with non-zero registers in view.
        write_reg(5'd9, ones);
        write_reg(5'd20, msb_lsb);
        addr_a = 5'd9;
        addr_b = 5'd20;
        Rs1 = addr_a;
        Rs2 = addr_b;
        @(negedge clk);
        #1;
        check("pre_async_rout1", Rout1, ones);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check("async_reset_rout1", Rout1, '0);
        check("async_reset_rout2", Rout2, '0);

        // A write edge during reset stores nothing.
        WriteEn   = 1'b1;
        rd        = addr_a;
        InputData = ones;
        @(posedge clk);
        #1;
        check("write_during_reset", Rout1, '0);
        @(negedge clk);
        WriteEn = 1'b0;
        rst     = 1'b1;
        #1;
        check("after_reset_release", Rout1, '0);
        for (int i = 0; i < NUM_REGS; i++) begin
            Rs1 = ADDR_W'(i);
            Rs2 = ADDR_W'(NUM_REGS - 1 - i);
            #1;
            check_ports("post_async_sweep");
        end

        // State is usable again after reset.
        write_reg(5'd12, DATA_W'(32'hDEAD_BEEF));
        Rs1 = 5'd12;
        #1;
        check("write_after_reset", Rout1, DATA_W'(32'hDEAD_BEEF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_reg_file.md
Name: vec_reg_file

Overview:
- Vector register file for the decode stage of the vector processor.
- 32 entries × 256 bits.
- Two asynchronous (combinational) read ports feed the operand path.
- One synchronous write port is driven by writeback.
- Top-level wrapper of the vector register storage.

Parameters:
- DATA_W, 256, width of each vector register (for example, 8 lanes × 32 bits; the lane structure is opaque to this block).
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of registers (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all registers.
- WriteEn  input  1  write enable, sampled at the rising edge of clk.
- Rs1  input  ADDR_W  read address, port 1.
- Rs2  input  ADDR_W  read address, port 2.
- rd  input  ADDR_W  write address.
- InputData  input  DATA_W  write data.
- Rout1  output  DATA_W  contents of register Rs1.
- Rout2  output  DATA_W  contents of register Rs2.

Behaviour:
- Storage: NUM_REGS registers of DATA_W bits each. All indices 0..31 are ordinary writable registers; none is hardwired to zero.
- Reset:
  - When rst=0, all registers clear to 0 immediately, independent of clk.
  - Rout1 and Rout2 therefore read 0 during and after reset.
  - Reset dominates any write in the same cycle.
  - A reset asserted mid-operation discards all previously written data.
- Write:
  - At a rising edge of clk with rst=1 and WriteEn=1, reg[rd] <= InputData.
  - WriteEn=0 means no state change.
  - WriteEn, rd and InputData are sampled only at the edge; changes between edges have no effect.
- Read:
  - Rout1 = reg[Rs1] and Rout2 = reg[Rs2], purely combinational with zero-cycle latency.
  - Outputs follow address changes within the same cycle.
- Read-during-write (same address, same cycle): no bypass.
  - The read port shows the old value until the rising edge.
  - It shows the new value immediately after the edge.
- Rs1 = Rs2: both outputs carry the identical value.
- Only the addressed register changes on a write; all others hold.
- Addresses are full range, so there is no out-of-range case.
- Full DATA_W width is stored with no truncation or sign handling.
- There are no X outputs after reset.

Test Plan:
- Reset: drive rst=0 for 2 cycles, then release → Rout1 = Rout2 = 0 for every Rs1/Rs2 in 0..31.
- Basic write/read:
  - Rs1=16, Rs2=18, rd=16, InputData=100, pulse WriteEn over one rising edge → Rout1=100 after that edge, Rout2=0.
  - Then rd=18 with WriteEn pulsed → Rout2=100, Rout1 still 100.
- Enable gating: set rd=5, InputData=256'hFF…FF, WriteEn=0 for 3 edges → reg5 stays 0. Changing InputData while WriteEn=0 also has no effect.
- No bypass: Rs1=rd=7, WriteEn=1, InputData=0xABCD → Rout1=0 before the edge and 0xABCD immediately after.
- Full width and isolation:
  - Write 256'h8000…0001 to reg31 and 256'h1 to reg0.
  - Read both through Rs1 and Rs2 → exact values, MSB preserved; neighbours reg30 and reg1 remain 0.
- Async reset mid-operation: after several writes, assert rst=0 between clock edges → all outputs drop to 0 without waiting for a clock edge. A WriteEn=1 edge during reset writes nothing.
